// File: rtl/ps2_dev_tx.sv
// rtl/ps2_dev_tx.sv - PS/2 device-side byte transmitter with host-inhibit retry
// Ports: clk, rst_n           - system clock, synchronous active-low reset
//        tx_data/tx_valid/tx_ready - byte request handshake
//        ps2_clk_i            - raw PS/2 clock line (asynchronous)
//        ps2_clk_oe/ps2_data_oe - open-drain pull-low enables
//        tx_done/tx_abort     - one-cycle frame-complete / inhibit-abort pulses
module ps2_dev_tx #(
  parameter int HALF_PERIOD      = 4000,
  parameter int IDLE_HIGH_CYCLES = 5000,
  parameter int GAP_CYCLES       = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_done,
  output logic       tx_abort
);

  localparam int MAX_AB  = (HALF_PERIOD > IDLE_HIGH_CYCLES) ? HALF_PERIOD : IDLE_HIGH_CYCLES;
  localparam int MAX_CNT = (MAX_AB > GAP_CYCLES) ? MAX_AB : GAP_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_BUS, SETUP, LOW, TAIL, GAP, ABORT
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    k, k_n;
  logic [7:0]    data_q, data_n;
  logic          parity_q, parity_n;
  logic          done_q, done_n;
  logic          clk_s1, clk_s;
  logic [10:0]   frame;

  // Frame as driven on the wire, index = bit position k.
  assign frame = {1'b1, parity_q, data_q, 1'b0};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      k        <= '0;
      data_q   <= '0;
      parity_q <= 1'b0;
      done_q   <= 1'b0;
      clk_s1   <= 1'b1;
      clk_s    <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      k        <= k_n;
      data_q   <= data_n;
      parity_q <= parity_n;
      done_q   <= done_n;
      clk_s1   <= ps2_clk_i;
      clk_s    <= clk_s1;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    k_n         = k;
    data_n      = data_q;
    parity_n    = parity_q;
    done_n      = 1'b0;
    tx_ready    = 1'b0;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    tx_abort    = 1'b0;
    tx_done     = done_q;

    case (state)
      IDLE: begin
        tx_ready = 1'b1;
        cnt_n    = '0;
        if (tx_valid) begin
          data_n   = tx_data;
          parity_n = ~^tx_data;
          state_n  = WAIT_BUS;
        end
      end
      WAIT_BUS: begin
        // Any low sample restarts the idle-high qualification.
        if (!clk_s) begin
          cnt_n = '0;
        end else if (cnt == CW'(IDLE_HIGH_CYCLES - 1)) begin
          cnt_n   = '0;
          k_n     = '0;
          state_n = SETUP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      SETUP: begin
        ps2_data_oe = ~frame[k];
        if (cnt == CW'(HALF_PERIOD - 1)) begin
          cnt_n = '0;
          // The start bit carries no inhibit check; later bits abort if the
          // host is holding the released clock low.
          if (k != 4'd0 && !clk_s) state_n = ABORT;
          else                     state_n = LOW;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      LOW: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = ~frame[k];
        if (cnt == CW'(HALF_PERIOD - 1)) begin
          cnt_n = '0;
          if (k == 4'd10) begin
            state_n = TAIL;
          end else begin
            k_n     = k + 4'd1;
            state_n = SETUP;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      TAIL: begin
        if (cnt == CW'(HALF_PERIOD - 1)) begin
          cnt_n   = '0;
          done_n  = 1'b1;
          state_n = GAP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == CW'(GAP_CYCLES - 1)) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ABORT: begin
        // Latched byte is kept so the frame restarts from the start bit.
        tx_abort = 1'b1;
        cnt_n    = '0;
        state_n  = WAIT_BUS;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_dev_tx.sv
// tb/tb_ps2_dev_tx.sv - self-checking bench for ps2_dev_tx with pull-up bus model
module tb_ps2_dev_tx;

  localparam int HP      = 4;
  localparam int IDLE_HI = 8;
  localparam int GAP     = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       tx_done;
  logic       tx_abort;
  logic       host_low;
  logic       clk_line;
  logic       data_line;

  always #5 clk = ~clk;

  // Open-drain lines with pull-ups; the host may also pull the clock low.
  assign clk_line  = ~(ps2_clk_oe | host_low);
  assign data_line = ~ps2_data_oe;

  ps2_dev_tx #(
    .HALF_PERIOD     (HP),
    .IDLE_HIGH_CYCLES(IDLE_HI),
    .GAP_CYCLES      (GAP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_i  (clk_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx_done    (tx_done),
    .tx_abort   (tx_abort)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Wire image of a byte: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic [10:0] f;
    f    = '0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i + 1] = b[i];
    f[9]  = (($countones(b) % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  logic [7:0]  exp_q[$];
  logic [10:0] obs = '0;
  int          nbits = 0;
  int          cyc = 0;
  int          n_acc = 0;
  int          n_done = 0;
  int          n_abort = 0;
  int          accept_cyc = 0;
  int          first_fall_cyc = 0;
  int          done_cyc = 0;
  int          abort_nbits = -1;
  logic        ready_q = 1'b0;
  logic        line_q = 1'b1;

  // Reference monitor: samples 1 time unit after each active edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      nbits = 0;
    end else begin
      if (ready_q && tx_valid) begin
        exp_q.push_back(tx_data);
        accept_cyc = cyc;
        n_acc++;
      end
      if (line_q && !clk_line && !host_low) begin
        if (nbits == 0) first_fall_cyc = cyc;
        if (nbits < 11) obs[nbits] = data_line;
        nbits++;
      end
      if (tx_abort) begin
        n_abort++;
        abort_nbits = nbits;
        check("abort_lines_released", int'({ps2_clk_oe, ps2_data_oe}), 0);
        nbits = 0;
      end
      if (tx_done) begin
        n_done++;
        done_cyc = cyc;
        check("done_has_pending_byte", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          check("frame_edge_count", nbits, 11);
          check("frame_bits", int'(obs), int'(model_frame(exp_q[0])));
          void'(exp_q.pop_front());
        end
        nbits = 0;
      end
    end
    ready_q = tx_ready;
    line_q  = clk_line;
  end

  // Called at a negedge; returns at the negedge after the byte is taken.
  task automatic send(input logic [7:0] b, input bit keep);
    int  a0;
    bit  ok;
    a0       = n_acc;
    ok       = 1'b0;
    tx_data  = b;
    tx_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (n_acc != a0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 0, 1);
    if (!keep) tx_valid = 1'b0;
  endtask

  task automatic wait_done(input int tgt);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (n_done >= tgt) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("done_timeout", n_done, tgt);
  endtask

  task automatic wait_bits(input int nb, input logic lvl);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (nbits == nb && clk_line == lvl) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("wait_bits_timeout", nbits, nb);
  endtask

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (tx_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("ready_timeout", 0, 1);
  endtask

  initial begin
    int tgt;
    int ab0;
    int rel;
    int d0;

    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;
    host_low = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_ready", int'(tx_ready), 1);
    check("rst_clk_oe", int'(ps2_clk_oe), 0);
    check("rst_data_oe", int'(ps2_data_oe), 0);
    check("rst_tx_done", int'(tx_done), 0);
    check("rst_tx_abort", int'(tx_abort), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte: frame image, latency and gap.
    send(8'hA5, 1'b0);
    check("a5_not_ready_after_accept", int'(tx_ready), 0);
    wait_done(1);
    check("a5_first_fall", first_fall_cyc - accept_cyc, IDLE_HI + HP);
    check("a5_done_latency", done_cyc - accept_cyc, IDLE_HI + 23 * HP);
    d0 = done_cyc;
    wait_ready();
    check("a5_gap", cyc - d0, GAP);

    // Back to back with tx_valid held high.
    ab0 = n_abort;
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    check("b2b_ff_accept_after_gap", accept_cyc - done_cyc, GAP + 1);
    send(8'h01, 1'b0);
    check("b2b_01_accept_after_gap", accept_cyc - done_cyc, GAP + 1);
    wait_done(4);
    check("b2b_no_abort", n_abort - ab0, 0);

    // Host inhibit while waiting for the bus.
    wait_ready();
    tgt = n_done + 1;
    send(8'($urandom), 1'b0);
    host_low = 1'b1;
    repeat (20) @(negedge clk);
    check("inhibit_no_edges", nbits, 0);
    host_low = 1'b0;
    rel = cyc;
    wait_done(tgt);
    check("inhibit_first_fall", first_fall_cyc - rel, 2 + IDLE_HI + HP);

    // Inhibit across the SETUP phase of bit 5.
    wait_ready();
    tgt = n_done + 1;
    ab0 = n_abort;
    send(8'($urandom), 1'b0);
    wait_bits(5, 1'b1);
    host_low = 1'b1;
    repeat (HP + 2) @(negedge clk);
    host_low = 1'b0;
    wait_done(tgt);
    check("abort_count", n_abort - ab0, 1);
    check("abort_at_bit5", abort_nbits, 5);

    // Reset during the low phase of bit 3.
    wait_ready();
    tgt = n_done;
    ab0 = n_abort;
    send(8'($urandom), 1'b0);
    wait_bits(4, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_clk_oe", int'(ps2_clk_oe), 0);
    check("midrst_data_oe", int'(ps2_data_oe), 0);
    check("midrst_tx_ready", int'(tx_ready), 1);
    repeat (30) @(negedge clk);
    check("midrst_no_done", n_done, tgt);
    check("midrst_no_abort", n_abort, ab0);
    send(8'($urandom), 1'b0);
    wait_done(tgt + 1);

    // Host pulls clock low during the tail: frame still completes.
    wait_ready();
    tgt = n_done + 1;
    ab0 = n_abort;
    send(8'($urandom), 1'b0);
    wait_bits(11, 1'b1);
    host_low = 1'b1;
    repeat (3) @(negedge clk);
    host_low = 1'b0;
    wait_done(tgt);
    check("tail_no_abort", n_abort - ab0, 0);

    // Random bytes with random idle spacing.
    for (int i = 0; i < 4; i++) begin
      wait_ready();
      repeat ($urandom_range(0, 5)) @(negedge clk);
      tgt = n_done + 1;
      send(8'($urandom), 1'b0);
      wait_done(tgt);
    end

    wait_ready();
    check("queue_drained", exp_q.size(), 0);
    check("total_done", n_done, 12);
    check("total_abort", n_abort, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
